// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared types and helpers for the gate responder
// Purpose: FSM state encodings and the counter-width helper used by the
//          gate_responder top and its receive deserialiser.
// Ports:   none (package).
package gate_pkg;

   typedef enum logic {T_IDLE, T_SETTLE} tx_state_t;
   typedef enum logic {R_IDLE, R_STORE}  rx_state_t;

   // Width needed to hold the values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/gate_responder_if.sv
// rtl/gate_responder_if.sv - controller-to-gate strobe/ready bundle
// Purpose: groups the controller's broadcast strobes and the gate's ready
//          returns so the controller and each gate share one connection.
// Signals: gen_sync, tx_start, rx_pull, tx_data (controller -> gate)
//          tx_ready, rx_ready (gate -> controller)
interface gate_responder_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  gen_sync;
   logic                  tx_start;
   logic                  rx_pull;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_ready;
   logic                  rx_ready;

   modport master (
      output gen_sync, tx_start, rx_pull, tx_data,
      input  tx_ready, rx_ready
   );

   modport slave (
      input  gen_sync, tx_start, rx_pull, tx_data,
      output tx_ready, rx_ready
   );
endinterface

// File: rtl/gate_rx_deser.sv
// rtl/gate_rx_deser.sv - receive deserialiser of one gate
// Purpose: samples the serial line on each pull strobe, assembles an
//          MSB-first word, publishes it with a one-cycle valid pulse.
// Ports:   i_clk, i_rst (async, active-high), i_sync (clear progress),
//          i_pull (sample strobe), i_line (serial in), o_ready (idle),
//          o_data (last word), o_valid (word pulse), o_count (bits so far)
module gate_rx_deser
   import gate_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_sync,
   input  logic                               i_pull,
   input  logic                               i_line,
   output logic                               o_ready,
   output logic [DATA_WIDTH-1:0]              o_data,
   output logic                               o_valid,
   output logic [cnt_w(DATA_WIDTH)-1:0]       o_count
);
   localparam int CW = cnt_w(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   rx_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shifted;

   assign w_shifted = {r_shift[DATA_WIDTH-2:0], i_line};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= R_IDLE;
         r_shift <= '0;
         o_ready <= 1'b1;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_count <= '0;
      end else if (i_sync) begin
         // o_data is deliberately kept: it is the last completed word.
         r_state <= R_IDLE;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_count <= '0;
      end else begin
         o_valid <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (i_pull) begin
                  r_shift <= w_shifted;
                  o_ready <= 1'b0;
                  r_state <= R_STORE;
                  if (o_count == LAST_BIT) begin
                     o_data  <= w_shifted;
                     o_valid <= 1'b1;
                     o_count <= '0;
                  end else begin
                     o_count <= o_count + 1'b1;
                  end
               end
            end
            R_STORE: begin
               // Pulls arriving here are protocol violations and dropped.
               o_ready <= 1'b1;
               r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/gate_responder.sv
// rtl/gate_responder.sv - per-gate responder to the sequencing controller
// Purpose: shifts a loaded word out MSB-first one bit per tx start, holding
//          tx_ready low while the line settles; receive side lives in
//          gate_rx_deser.
// Ports:   i_clk, i_rst (async, active-high), bus (slave strobe/ready
//          bundle), i_rx_line, o_tx_line, o_rx_data, o_rx_valid, o_bit_count
module gate_responder
   import gate_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   gate_responder_if.slave                    bus,
   input  logic                               i_rx_line,
   output logic                               o_tx_line,
   output logic [DATA_WIDTH-1:0]              o_rx_data,
   output logic                               o_rx_valid,
   output logic [cnt_w(DATA_WIDTH)-1:0]       o_bit_count
);
   localparam int CW = cnt_w(DATA_WIDTH);
   localparam int SW = cnt_w(SETTLE_CYCLES);
   localparam logic [CW-1:0] ALL_SENT    = CW'(DATA_WIDTH);
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);

   tx_state_t             r_tx_state;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [CW-1:0]         r_sent;
   logic [SW-1:0]         r_settle;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_state   <= T_IDLE;
         r_tx_shift   <= '0;
         r_sent       <= '0;
         r_settle     <= '0;
         o_tx_line    <= 1'b0;
         bus.tx_ready <= 1'b1;
      end else if (bus.gen_sync) begin
         r_tx_state   <= T_IDLE;
         r_tx_shift   <= bus.tx_data;
         r_sent       <= '0;
         r_settle     <= '0;
         bus.tx_ready <= 1'b1;
      end else begin
         case (r_tx_state)
            T_IDLE: begin
               if (bus.tx_start) begin
                  // Past the end of the word the gate keeps answering with
                  // zeros so the controller's ready AND never stalls.
                  if (r_sent == ALL_SENT) begin
                     o_tx_line <= 1'b0;
                  end else begin
                     o_tx_line  <= r_tx_shift[DATA_WIDTH-1];
                     r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                     r_sent     <= r_sent + 1'b1;
                  end
                  r_settle     <= SETTLE_INIT;
                  bus.tx_ready <= 1'b0;
                  r_tx_state   <= T_SETTLE;
               end
            end
            T_SETTLE: begin
               if (r_settle == SW'(1)) begin
                  bus.tx_ready <= 1'b1;
                  r_tx_state   <= T_IDLE;
               end else begin
                  r_settle <= r_settle - 1'b1;
               end
            end
            default: r_tx_state <= T_IDLE;
         endcase
      end
   end

   gate_rx_deser #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rx (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_sync  (bus.gen_sync),
      .i_pull  (bus.rx_pull),
      .i_line  (i_rx_line),
      .o_ready (bus.rx_ready),
      .o_data  (o_rx_data),
      .o_valid (o_rx_valid),
      .o_count (o_bit_count)
   );
endmodule

// File: tb/tb_gate_responder.sv
// tb/tb_gate_responder.sv - directed self-checking bench for gate_responder
module tb_gate_responder;
   localparam int DW = 8;
   localparam int SC = 3;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          w_line;
   logic [DW-1:0] w_rx_data;
   logic          w_rx_valid;
   logic [3:0]    w_bit_count;

   int vectors     = 0;
   int miscompares = 0;

   gate_responder_if #(.DATA_WIDTH(DW)) bus ();

   gate_responder #(
      .DATA_WIDTH    (DW),
      .SETTLE_CYCLES (SC)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .bus         (bus),
      .i_rx_line   (w_line),
      .o_tx_line   (w_line),
      .o_rx_data   (w_rx_data),
      .o_rx_valid  (w_rx_valid),
      .o_bit_count (w_bit_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_sync(input logic [DW-1:0] data);
      bus.gen_sync = 1'b1;
      bus.tx_data  = data;
      tick();
      bus.gen_sync = 1'b0;
   endtask

   task automatic strobe(input logic tx, input logic rx);
      bus.tx_start = tx;
      bus.rx_pull  = rx;
      tick();
      bus.tx_start = 1'b0;
      bus.rx_pull  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(bus.tx_ready && bus.rx_ready) && n < 20) begin
         tick();
         n++;
      end
      if (!(bus.tx_ready && bus.rx_ready)) begin
         miscompares++;
         $display("FAIL wait_idle: readies tx=%b rx=%b, required both 1", bus.tx_ready, bus.rx_ready);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      vectors++;
      if ({bus.tx_ready, bus.rx_ready, w_line, w_rx_valid} !== 4'b1100) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, required 1100", {bus.tx_ready, bus.rx_ready, w_line, w_rx_valid});
      end
      vectors++;
      if (w_rx_data !== 8'h00 || w_bit_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_data: data=%h count=%0d, required 00/0", w_rx_data, w_bit_count);
      end
      i_rst = 1'b0;
      tick();
      // Reset in the middle of a settle and a store.
      do_sync(8'h80);
      strobe(1'b1, 1'b1);
      vectors++;
      if (bus.tx_ready !== 1'b0 || w_line !== 1'b1 || w_bit_count !== 4'd1) begin
         miscompares++;
         $display("FAIL pre_reset: rdy=%b line=%b count=%0d, required 0/1/1", bus.tx_ready, w_line, w_bit_count);
      end
      i_rst = 1'b1;
      tick();
      vectors++;
      if (bus.tx_ready !== 1'b1 || bus.rx_ready !== 1'b1 || w_line !== 1'b0
          || w_bit_count !== 4'd0 || w_rx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: txr=%b rxr=%b line=%b count=%0d valid=%b, required 1/1/0/0/0",
                  bus.tx_ready, bus.rx_ready, w_line, w_bit_count, w_rx_valid);
      end
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_loopback();
      do_sync(8'hA5);
      strobe(1'b1, 1'b0);
      wait_idle();
      for (int i = 1; i <= DW; i++) begin
         strobe(1'b1, 1'b1);
         if (i == 3) begin
            vectors++;
            if (w_bit_count !== 4'd3) begin
               miscompares++;
               $display("FAIL loop_count3: got %0d, required 3", w_bit_count);
            end
         end
         if (i == DW - 1) begin
            vectors++;
            if (w_rx_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL loop_early_valid: got %b, required 0", w_rx_valid);
            end
         end
         if (i == DW) begin
            vectors++;
            if (w_rx_valid !== 1'b1 || w_rx_data !== 8'hA5 || w_bit_count !== 4'd0) begin
               miscompares++;
               $display("FAIL loop_word: valid=%b data=%h count=%0d, required 1/a5/0",
                        w_rx_valid, w_rx_data, w_bit_count);
            end
            tick();
            vectors++;
            if (w_rx_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL loop_valid_width: got %b, required 0", w_rx_valid);
            end
         end
         wait_idle();
      end
   endtask

   task automatic test_settle();
      int n;
      do_sync(8'hC3);
      strobe(1'b1, 1'b0);
      vectors++;
      if (w_line !== 1'b1 || bus.rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL settle_line: line=%b rxr=%b, required 1/1", w_line, bus.rx_ready);
      end
      n = 0;
      while (bus.tx_ready == 1'b0 && n < 10) begin
         n++;
         tick();
      end
      vectors++;
      if (n !== SC) begin
         miscompares++;
         $display("FAIL settle_len: low %0d cycles, required %0d", n, SC);
      end
   endtask

   task automatic test_start_during_settle();
      int n;
      do_sync(8'h40);
      strobe(1'b1, 1'b0);
      n = 1;
      bus.tx_start = 1'b1;
      tick();
      bus.tx_start = 1'b0;
      while (bus.tx_ready == 1'b0 && n < 10) begin
         n++;
         tick();
      end
      vectors++;
      if (n !== SC || w_line !== 1'b0) begin
         miscompares++;
         $display("FAIL ignored_start: low %0d line=%b, required %0d/0", n, w_line, SC);
      end
      strobe(1'b1, 1'b0);
      vectors++;
      if (w_line !== 1'b1) begin
         miscompares++;
         $display("FAIL second_bit: line=%b, required 1", w_line);
      end
      wait_idle();
   endtask

   task automatic test_sync_abort();
      do_sync(8'hFF);
      for (int i = 0; i < 5; i++) begin
         strobe(1'b0, 1'b1);
         wait_idle();
      end
      vectors++;
      if (w_bit_count !== 4'd5) begin
         miscompares++;
         $display("FAIL abort_count5: got %0d, required 5", w_bit_count);
      end
      do_sync(8'hFF);
      vectors++;
      if (w_bit_count !== 4'd0 || w_rx_valid !== 1'b0 || w_rx_data !== 8'hA5) begin
         miscompares++;
         $display("FAIL abort_sync: count=%0d valid=%b data=%h, required 0/0/a5",
                  w_bit_count, w_rx_valid, w_rx_data);
      end
      for (int i = 0; i < 3; i++) begin
         strobe(1'b0, 1'b1);
         vectors++;
         if (w_rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_valid: pull %0d valid=%b, required 0", i, w_rx_valid);
         end
         wait_idle();
      end
      vectors++;
      if (w_bit_count !== 4'd3) begin
         miscompares++;
         $display("FAIL abort_count3: got %0d, required 3", w_bit_count);
      end
   endtask

   task automatic test_ninth_start();
      int n;
      do_sync(8'hFF);
      for (int i = 0; i < DW; i++) begin
         strobe(1'b1, 1'b0);
         vectors++;
         if (w_line !== 1'b1) begin
            miscompares++;
            $display("FAIL ones_bit%0d: line=%b, required 1", i, w_line);
         end
         wait_idle();
      end
      strobe(1'b1, 1'b0);
      vectors++;
      if (w_line !== 1'b0) begin
         miscompares++;
         $display("FAIL ninth_line: line=%b, required 0", w_line);
      end
      n = 0;
      while (bus.tx_ready == 1'b0 && n < 10) begin
         n++;
         tick();
      end
      vectors++;
      if (n !== SC) begin
         miscompares++;
         $display("FAIL ninth_settle: low %0d cycles, required %0d", n, SC);
      end
   endtask

   initial begin
      bus.gen_sync = 1'b0;
      bus.tx_start = 1'b0;
      bus.rx_pull  = 1'b0;
      bus.tx_data  = '0;
      test_reset();
      test_loopback();
      test_settle();
      test_start_during_settle();
      test_sync_abort();
      test_ninth_start();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/gate_responder.md
# gate_responder

Gate-side counterpart of the gate-array sequencing controller: one instance per gate, consuming the controller's broadcast sync/tx-start/rx-pull strobes and returning per-gate tx_ready/rx_ready. Serialises a DATA_WIDTH-bit word MSB-first onto o_tx_line, deserialises i_rx_line into a word, and holds ready low while the line settles or a sample is stored. Its ready outputs feed the controller's ready AND-reduction, so the controller advances only when every gate is idle.

## Interface
- DATA_WIDTH, 8: bits per transferred word; ≥2.
- SETTLE_CYCLES, 2: cycles o_tx_ready stays low after a tx start; ≥1.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_gen_sync  in  1  controller idle/sync level; reloads word, clears progress.
- i_tx_start  in  1  one-cycle strobe: drive next bit.
- i_rx_pull  in  1  one-cycle strobe: sample i_rx_line.
- i_tx_data  in  DATA_WIDTH  word to send, captured while i_gen_sync=1.
- i_rx_line  in  1  serial input from neighbour gate's o_tx_line.
- o_tx_line  out  1  serial output, registered.
- o_tx_ready  out  1  transmitter idle.
- o_rx_ready  out  1  receiver idle.
- o_rx_data  out  DATA_WIDTH  last completed received word.
- o_rx_valid  out  1  one-cycle pulse, o_rx_data updated.
- o_bit_count  out  $clog2(DATA_WIDTH+1)  bits received in current word.

## Operation
- Reset values: o_tx_line=0, o_tx_ready=1, o_rx_ready=1, o_rx_data=0, o_rx_valid=0, o_bit_count=0; tx shift register 0, tx sent-count 0.
- Sync: every cycle i_gen_sync=1: tx shift register ← i_tx_data, sent-count←0, rx count←0, o_rx_valid←0, both FSMs → IDLE, readies←1. Sync overrides strobes in same cycle; aborts settle/store in progress. o_rx_data retained.
- TX FSM, states T_IDLE, T_SETTLE:
  - T_IDLE (o_tx_ready=1): on i_tx_start, o_tx_line←shift[MSB], shift left by 1 (zero fill), sent-count+1, settle counter←SETTLE_CYCLES, → T_SETTLE.
  - If sent-count = DATA_WIDTH at tx start: o_tx_line←0, no shift, still settles (controller never deadlocks).
  - T_SETTLE (o_tx_ready=0): decrement counter; at 1 → T_IDLE.
  - i_tx_start in T_SETTLE: protocol violation, ignored.
- RX FSM, states R_IDLE, R_STORE:
  - R_IDLE (o_rx_ready=1): on i_rx_pull, rx shift ← {rx shift[DATA_WIDTH-2:0], i_rx_line}, o_bit_count+1, → R_STORE.
  - Completing bit (count DATA_WIDTH-1 → DATA_WIDTH): o_rx_data←shifted word, o_rx_valid=1 for one cycle, o_bit_count←0.
  - R_STORE (o_rx_ready=0): one cycle, → R_IDLE. i_rx_pull here ignored.
- Simultaneous i_tx_start and i_rx_pull (controller's clocked state): rx samples pre-edge i_rx_line, tx updates o_tx_line on same edge; ring of gates shifts one position per strobe.

## Timing
- All outputs registered; readies fall on the edge that samples the strobe, so the controller's wait state sees 0 in its first cycle.
- o_tx_ready low exactly SETTLE_CYCLES cycles per tx start; o_rx_ready low exactly 1 cycle per pull.
- o_rx_valid asserted the cycle after the edge sampling the DATA_WIDTH-th pull.
- Reset asserted mid-transfer: all state to reset values immediately; no valid pulse.
- Full word: one tx start then DATA_WIDTH combined tx-start/rx-pull strobes; neighbour's first bit appears on the first (tx-only) strobe.

## Structure
- gate_pkg: tx_state_t {T_IDLE,T_SETTLE}, rx_state_t {R_IDLE,R_STORE}, count-width function.
- Sub-module gate_rx_deser: RX FSM, shift register, bit counter, valid pulse; top holds TX FSM and settle counter.

## Test plan
- Reset mid-settle → next cycle o_tx_ready=1, o_tx_line=0, o_bit_count=0, o_rx_valid=0.
- DATA_WIDTH=8, i_tx_data=0xA5, loopback o_tx_line→i_rx_line, controller-model sequence (sync, start, 8× tx+pull) → o_rx_valid one cycle, o_rx_data=0xA5.
- Single i_tx_start, SETTLE_CYCLES=3 → o_tx_ready low exactly 3 cycles, o_tx_line=MSB of loaded word.
- i_tx_start repeated during T_SETTLE → ignored; settle length unchanged, one bit consumed.
- i_gen_sync after 5 of 8 pulls → o_bit_count=0, no o_rx_valid, o_rx_data unchanged (previous word).
- 9th tx start after 8 bits sent → o_tx_line=0, o_tx_ready still drops for SETTLE_CYCLES.
